data_sram_responder: RTL and testbench

//  Responder (slave) end of the CPU data-SRAM-like interface; the MEM stage consumes its rdata.

---
 rtl/data_sram_responder_pkg.sv | 13 +
 rtl/data_sram_responder_resp_req_fifo.sv | 59 +++++
 rtl/data_sram_responder.sv | 95 +++++++++
 tb/tb_data_sram_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: transfer size encodings and
// the width of a packed queue entry {wr, word index, wstrb, wdata}.
package data_sram_responder_pkg;

  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;

  function automatic int dsram_req_wd(input int aw);
    return 1 + aw + 4 + 32;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_req_fifo.sv
// In-order request queue for the responder: synchronous FIFO with a
// combinational head, natural-wrap pointers and an extra count bit for full.
module data_sram_responder_resp_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM interface: queues requests in order and
// retires each one LAT cycles after it reaches the head, touching memory only at retire.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int    AW        = 10,
  parameter int    QDEPTH    = 4,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int REQ_WD    = dsram_req_wd(AW);
  localparam int CW        = $clog2(QDEPTH) + 1;
  localparam int AGE_W     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int MEM_WORDS = 1 << AW;

  logic [31:0]       mem [MEM_WORDS];
  logic [REQ_WD-1:0] push_entry;
  logic [REQ_WD-1:0] head;
  logic [CW-1:0]     count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [AGE_W-1:0]  age;

  logic              head_wr;
  logic [AW-1:0]     head_idx;
  logic [3:0]        head_strb;
  logic [31:0]       head_wdata;

  // Upper address bits wrap, byte offset and size are informational only.
  logic unused_ok;
  assign unused_ok = ^{addr[31:AW+2], addr[1:0], size, fifo_full};

  assign push_entry = {wr, addr[AW+1:2], wstrb, wdata};
  assign head_wr    = head[REQ_WD-1];
  assign head_idx   = head[REQ_WD-2 -: AW];
  assign head_strb  = head[35:32];
  assign head_wdata = head[31:0];

  assign addr_ok = (count != CW'(QDEPTH));
  assign push    = req && addr_ok;
  assign data_ok = !fifo_empty && (age == AGE_W'(LAT - 1));
  assign pop     = data_ok;
  assign rdata   = (data_ok && !head_wr) ? mem[head_idx] : 32'd0;

  data_sram_responder_resp_req_fifo #(
    .W     (REQ_WD),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Age counts cycles the current head has waited; an empty queue holds it at 0
  // so a freshly pushed entry starts its first head cycle at age 0.
  always_ff @(posedge clk) begin
    if (reset || pop) begin
      age <= '0;
    end else if (!fifo_empty) begin
      age <= age + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && head_wr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (head_strb[i]) begin
          mem[head_idx][8*i +: 8] <= head_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances (LAT=1, 2, 3) share
// clock and reset; inputs are driven and outputs sampled 1 time unit after posedge.
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        req_s   [3];
  logic        wr_s    [3];
  logic [1:0]  size_s  [3];
  logic [31:0] addr_s  [3];
  logic [3:0]  wstrb_s [3];
  logic [31:0] wdata_s [3];
  logic        aok_s   [3];
  logic        dok_s   [3];
  logic [31:0] rdata_s [3];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  data_sram_responder #(.AW(10), .QDEPTH(4), .LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
    .addr(addr_s[0]), .wstrb(wstrb_s[0]), .wdata(wdata_s[0]),
    .addr_ok(aok_s[0]), .data_ok(dok_s[0]), .rdata(rdata_s[0])
  );

  data_sram_responder #(.AW(10), .QDEPTH(4), .LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
    .addr(addr_s[1]), .wstrb(wstrb_s[1]), .wdata(wdata_s[1]),
    .addr_ok(aok_s[1]), .data_ok(dok_s[1]), .rdata(rdata_s[1])
  );

  data_sram_responder #(.AW(10), .QDEPTH(4), .LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .req(req_s[2]), .wr(wr_s[2]), .size(size_s[2]),
    .addr(addr_s[2]), .wstrb(wstrb_s[2]), .wdata(wdata_s[2]),
    .addr_ok(aok_s[2]), .data_ok(dok_s[2]), .rdata(rdata_s[2])
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic rq, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req_s[k]   = rq;
    wr_s[k]    = w;
    size_s[k]  = 2'd2;
    addr_s[k]  = a;
    wstrb_s[k] = s;
    wdata_s[k] = d;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic check_out(input int k, input string tag, input logic aok, input logic dok,
                           input logic [31:0] rd);
    check({tag, ".addr_ok"}, {31'd0, aok_s[k]}, {31'd0, aok});
    check({tag, ".data_ok"}, {31'd0, dok_s[k]}, {31'd0, dok});
    check({tag, ".rdata"}, rdata_s[k], rd);
  endtask

  // One complete transaction: hold req until accepted, then wait for its response.
  task automatic xfer(input int k, input string tag, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    int n;
    drive(k, 1'b1, w, a, s, d);
    n = 0;
    while (!aok_s[k] && n < 20) begin
      step();
      n++;
    end
    check({tag, ".accepted"}, {31'd0, aok_s[k]}, 32'd1);
    step();
    idle(k);
    n = 0;
    while (!dok_s[k] && n < 20) begin
      step();
      n++;
    end
    check({tag, ".responded"}, {31'd0, dok_s[k]}, 32'd1);
    rd = rdata_s[k];
    step();
  endtask

  logic [31:0] rd;
  logic [0:10] aok_exp;
  logic        dok_exp;
  logic        acc;
  int          na;

  initial begin
    for (int k = 0; k < 3; k++) idle(k);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) check_out(k, $sformatf("reset[%0d]", k), 1'b1, 1'b0, 32'd0);

    // LAT=1 write then read, one response per cycle
    drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678);
    check_out(0, "t1.c0", 1'b1, 1'b0, 32'd0);
    step();
    drive(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'd0);
    check_out(0, "t1.c1", 1'b1, 1'b1, 32'd0);
    step();
    idle(0);
    check_out(0, "t1.c2", 1'b1, 1'b1, 32'h12345678);
    step();
    check_out(0, "t1.c3", 1'b1, 1'b0, 32'd0);

    // Byte strobes and an all-zero strobe
    xfer(0, "t2.w0", 1'b1, 32'h40, 4'hF, 32'hAABBCCDD, rd);
    check("t2.w0.rdata", rd, 32'd0);
    xfer(0, "t2.w1", 1'b1, 32'h40, 4'b0100, 32'h00EE0000, rd);
    xfer(0, "t2.r1", 1'b0, 32'h40, 4'hF, 32'hFFFFFFFF, rd);
    check("t2.r1.rdata", rd, 32'hAAEECCDD);
    xfer(0, "t2.w2", 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, rd);
    xfer(0, "t2.r2", 1'b0, 32'h40, 4'h0, 32'd0, rd);
    check("t2.r2.rdata", rd, 32'hAAEECCDD);

    // Address wrap past 2**AW words
    xfer(0, "t6.w", 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, rd);
    xfer(0, "t6.r", 1'b0, 32'h0, 4'h0, 32'd0, rd);
    check("t6.r.rdata", rd, 32'hCAFEF00D);

    // LAT=2 read-after-write queued back to back
    xfer(1, "t4.pre", 1'b1, 32'h80, 4'hF, 32'hDEAD0000, rd);
    drive(1, 1'b1, 1'b1, 32'h80, 4'hF, 32'h1);
    check_out(1, "t4.u0", 1'b1, 1'b0, 32'd0);
    step();
    drive(1, 1'b1, 1'b0, 32'h80, 4'h0, 32'd0);
    check_out(1, "t4.u1", 1'b1, 1'b0, 32'd0);
    step();
    idle(1);
    check_out(1, "t4.u2", 1'b1, 1'b1, 32'd0);
    step();
    check_out(1, "t4.u3", 1'b1, 1'b0, 32'd0);
    step();
    check_out(1, "t4.u4", 1'b1, 1'b1, 32'h1);
    step();
    check_out(1, "t4.u5", 1'b1, 1'b0, 32'd0);

    // LAT=3 six back-to-back reads against a depth-4 queue
    for (int i = 0; i < 6; i++) begin
      xfer(2, $sformatf("t3.pre%0d", i), 1'b1, 32'(i * 4), 4'hF, 32'h30000000 + 32'(i), rd);
      check($sformatf("t3.pre%0d.rdata", i), rd, 32'd0);
    end
    aok_exp = 11'b11111001001;
    na = 0;
    for (int t = 0; t < 20; t++) begin
      if (na < 6) drive(2, 1'b1, 1'b0, 32'(na * 4), 4'h0, 32'd0);
      else idle(2);
      if (t <= 10) check($sformatf("t3.aok[%0d]", t), {31'd0, aok_s[2]}, {31'd0, aok_exp[t]});
      dok_exp = (t >= 3) && (t % 3 == 0);
      check($sformatf("t3.dok[%0d]", t), {31'd0, dok_s[2]}, {31'd0, dok_exp});
      if (dok_s[2]) begin
        if (exp_q.size() > 0) check($sformatf("t3.rdata[%0d]", t), rdata_s[2], exp_q.pop_front());
        else check($sformatf("t3.unexpected[%0d]", t), 32'd1, 32'd0);
      end else begin
        check($sformatf("t3.rdata_idle[%0d]", t), rdata_s[2], 32'd0);
      end
      acc = (na < 6) && aok_s[2];
      if (acc) exp_q.push_back(32'h30000000 + 32'(na));
      step();
      if (acc) na++;
    end
    idle(2);
    check("t3.accepted_all", 32'(na), 32'd6);
    check("t3.drained", 32'(exp_q.size()), 32'd0);

    // Reset with three requests queued; the queued write must never land
    xfer(2, "t5.pre", 1'b1, 32'h100, 4'hF, 32'h11111111, rd);
    drive(2, 1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
    check_out(2, "t5.v0", 1'b1, 1'b0, 32'd0);
    step();
    drive(2, 1'b1, 1'b0, 32'h4, 4'h0, 32'd0);
    step();
    drive(2, 1'b1, 1'b1, 32'h100, 4'hF, 32'h55555555);
    step();
    idle(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out(2, "t5.after_reset", 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t5.quiet[%0d]", i), {31'd0, dok_s[2]}, 32'd0);
    end
    xfer(2, "t5.r", 1'b0, 32'h100, 4'h0, 32'd0, rd);
    check("t5.r.rdata", rd, 32'h11111111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
